// File: rtl/a2d_pkg.sv
// Shared constants and state encoding for the SPI A2D slave model.
package a2d_pkg;
    localparam int FRAME_W    = 16;
    localparam int CH_FIELD_W = 3;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/spi_edge_sync.sv
// Brings SS_n and SCLK into the clk domain and flags their edges.
// Two flops resynchronise each line; a third holds the previous synced
// value so edges are seen one cycle later, giving 3 clk edge latency.
module spi_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic ss_n,
    input  logic sclk,
    output logic ss_lvl,
    output logic ss_fall,
    output logic ss_rise,
    output logic sclk_rise,
    output logic sclk_fall
);
    logic [2:0] ss_q;
    logic [2:0] sclk_q;

    // Both lines idle high, so the chains reset high to avoid false edges.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ss_q   <= 3'b111;
            sclk_q <= 3'b111;
        end else begin
            ss_q   <= {ss_q[1:0], ss_n};
            sclk_q <= {sclk_q[1:0], sclk};
        end
    end

    assign ss_lvl    = ss_q[1];
    assign ss_fall   = ss_q[2] & ~ss_q[1];
    assign ss_rise   = ~ss_q[2] & ss_q[1];
    assign sclk_rise = ~sclk_q[2] & sclk_q[1];
    assign sclk_fall = sclk_q[2] & ~sclk_q[1];
endmodule

// File: rtl/a2d_spi_slave.sv
// Multi-channel SPI A2D converter model. Each 16-bit frame returns the
// channel chosen by the previous complete frame, optionally ramping.
module a2d_spi_slave
    import a2d_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 12,
    parameter int CH_LSB = 11
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     SS_n,
    input  logic                     SCLK,
    input  logic                     MOSI,
    output logic                     MISO,
    input  logic [NUM_CH*DATA_W-1:0] ch_val,
    input  logic [NUM_CH-1:0]        ramp_en,
    input  logic [DATA_W-1:0]        ramp_step,
    output logic [15:0]              xfer_cnt,
    output logic                     err_ch
);
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_t                       state, state_nx;
    logic [FRAME_W-1:0]           tx, rx;
    logic [4:0]                   bit_cnt;
    logic [SEL_W-1:0]             sel;
    logic [NUM_CH-1:0][DATA_W-1:0] offset;
    logic                         ramp_lat;
    logic [DATA_W-1:0]            step_lat;
    logic [DATA_W-1:0]            base_sel, off_sel, data_sel;
    logic                         ramp_sel;
    logic [FRAME_W-1:0]           frame_val;
    logic [CH_FIELD_W-1:0]        field;
    logic                         ss_lvl, ss_fall, ss_rise, sclk_rise, sclk_fall;

    spi_edge_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .ss_n      (SS_n),
        .sclk      (SCLK),
        .ss_lvl    (ss_lvl),
        .ss_fall   (ss_fall),
        .ss_rise   (ss_rise),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall)
    );

    // Pick the selected channel's base, ramp offset and ramp enable.
    always_comb begin
        base_sel = '0;
        off_sel  = '0;
        ramp_sel = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (sel == SEL_W'(k)) begin
                base_sel = ch_val[k*DATA_W +: DATA_W];
                off_sel  = offset[k];
                ramp_sel = ramp_en[k];
            end
        end
    end

    assign data_sel  = base_sel + off_sel;
    assign frame_val = FRAME_W'(data_sel);
    assign field     = rx[CH_LSB +: CH_FIELD_W];
    assign MISO      = (state == IDLE) ? 1'b1 : tx[FRAME_W-1];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state: SS_n rising before all 16 bits arrive aborts the frame.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (ss_fall) state_nx = SHIFT;
            SHIFT: begin
                if (ss_rise)
                    state_nx = IDLE;
                else if (sclk_rise && !ss_lvl && bit_cnt == 5'd15)
                    state_nx = DONE;
            end
            DONE:  if (ss_rise) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Shift registers, ramp offsets, channel select and counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx       <= '0;
            rx       <= '0;
            bit_cnt  <= '0;
            sel      <= '0;
            offset   <= '0;
            ramp_lat <= 1'b0;
            step_lat <= '0;
            xfer_cnt <= '0;
            err_ch   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (ss_fall) begin
                    // Inputs are captured here so mid-frame changes wait a frame.
                    tx       <= frame_val;
                    bit_cnt  <= '0;
                    ramp_lat <= ramp_sel;
                    step_lat <= ramp_step;
                end
                SHIFT: if (!ss_rise && !ss_lvl) begin
                    if (sclk_rise) begin
                        rx      <= {rx[FRAME_W-2:0], MOSI};
                        bit_cnt <= bit_cnt + 5'd1;
                    end
                    // The leading fall presents bit 15 already loaded; no shift.
                    if (sclk_fall && bit_cnt != 5'd0)
                        tx <= {tx[FRAME_W-2:0], 1'b0};
                end
                DONE: if (ss_rise) begin
                    xfer_cnt <= xfer_cnt + 16'd1;
                    if (ramp_lat)
                        offset[sel] <= offset[sel] + step_lat;
                    if (int'(field) < NUM_CH)
                        sel <= field[SEL_W-1:0];
                    else
                        err_ch <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
